// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: reset constants, fetch FSM states and the IF/ID record.
package fetch_stage_pkg;

  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;
  localparam logic [31:0] NOP_INS_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StHold  = 2'b10,
    StDrop  = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] ins;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched word, stall holds.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INS = NOP_INS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        stall,
  input  logic [29:0] load_pc,
  input  logic [31:0] load_ins,
  output ifid_t       ifid
);

  ifid_t ifid_q;

  // A bubble keeps the old pc so ID still sees where the hole came from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_q.pc    <= '0;
      ifid_q.ins   <= NOP_INS;
      ifid_q.valid <= 1'b0;
    end else if (flush) begin
      ifid_q.ins   <= NOP_INS;
      ifid_q.valid <= 1'b0;
    end else if (load) begin
      ifid_q.pc    <= load_pc;
      ifid_q.ins   <= load_ins;
      ifid_q.valid <= 1'b1;
    end else if (!stall) begin
      ifid_q.ins   <= NOP_INS;
      ifid_q.valid <= 1'b0;
    end
  end

  assign ifid = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, multi-cycle imem request/ack handling, stall/flush control and IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc,
  output logic [29:0] pc,
  input  logic        stall,
  input  logic        if_flush,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [29:0] id_pc,
  output logic [31:0] id_ins,
  output logic        id_valid
);

  fetch_state_e state_q;
  logic [29:0]  pc_q;
  logic [29:0]  addr_q;
  logic         req_q;
  logic [31:0]  hold_q;

  logic         load;
  logic [31:0]  load_ins;
  ifid_t        ifid;

  // A word enters IF/ID either straight off the bus or from the stall buffer.
  always_comb begin
    load     = 1'b0;
    load_ins = imem_rdata;
    case (state_q)
      StFetch: load = imem_ack && !stall && !if_flush;
      StHold: begin
        load     = !stall && !if_flush;
        load_ins = hold_q;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      hold_q  <= NOP_INS;
    end else begin
      case (state_q)
        StIdle: begin
          req_q   <= 1'b1;
          state_q <= StFetch;
          if (if_flush) begin
            pc_q   <= npc;
            addr_q <= npc;
          end else begin
            addr_q <= pc_q;
          end
        end
        StFetch: begin
          if (if_flush) begin
            pc_q <= npc;
            // Without an ack the bus request cannot be retracted, so wait it out.
            if (imem_ack) addr_q <= npc;
            else          state_q <= StDrop;
          end else if (imem_ack) begin
            if (stall) begin
              hold_q  <= imem_rdata;
              req_q   <= 1'b0;
              state_q <= StHold;
            end else begin
              pc_q   <= npc;
              addr_q <= npc;
            end
          end
        end
        StHold: begin
          if (if_flush || !stall) begin
            pc_q    <= npc;
            addr_q  <= npc;
            req_q   <= 1'b1;
            state_q <= StFetch;
          end
        end
        StDrop: begin
          if (if_flush) pc_q <= npc;
          if (imem_ack) begin
            addr_q  <= if_flush ? npc : pc_q;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fetch_stage_ifid_reg #(
    .NOP_INS (NOP_INS)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .flush    (if_flush),
    .load     (load),
    .stall    (stall),
    .load_pc  (pc_q),
    .load_ins (load_ins),
    .ifid     (ifid)
  );

  assign pc        = pc_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_pc     = ifid.pc;
  assign id_ins    = ifid.ins;
  assign id_valid  = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/flush/ack traffic against a flag-based model.
module tb_fetch_stage;

  localparam logic [29:0] RST_PC = 30'h0000_0C00;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] npc;
  logic [29:0] pc;
  logic        stall;
  logic        if_flush;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [29:0] id_pc;
  logic [31:0] id_ins;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: what the stage has done, expressed as facts rather than states.
  logic        m_started;
  logic        m_buffered;
  logic        m_dropping;
  logic [31:0] m_buf;
  logic [29:0] m_pc;
  logic [29:0] m_addr;
  logic        m_req;
  logic [29:0] m_id_pc;
  logic [31:0] m_id_ins;
  logic        m_id_valid;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .pc         (pc),
    .stall      (stall),
    .if_flush   (if_flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_ins     (id_ins),
    .id_valid   (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started  = 1'b0;
    m_buffered = 1'b0;
    m_dropping = 1'b0;
    m_buf      = NOP;
    m_pc       = RST_PC;
    m_addr     = RST_PC;
    m_req      = 1'b0;
    m_id_pc    = '0;
    m_id_ins   = NOP;
    m_id_valid = 1'b0;
  endtask

  task automatic bubble();
    m_id_valid = 1'b0;
    m_id_ins   = NOP;
  endtask

  task automatic model_edge(input logic a, input logic s, input logic f,
                            input logic [29:0] n, input logic [31:0] rd);
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
      if (f) m_pc = n;
      m_addr = m_pc;
      bubble();
    end else if (m_buffered) begin
      if (f) begin
        m_pc = n; m_addr = n; m_req = 1'b1; m_buffered = 1'b0;
        bubble();
      end else if (!s) begin
        m_id_pc = m_pc; m_id_ins = m_buf; m_id_valid = 1'b1;
        m_pc = n; m_addr = n; m_req = 1'b1; m_buffered = 1'b0;
      end
    end else if (m_dropping) begin
      bubble();
      if (f) m_pc = n;
      if (a) begin
        m_dropping = 1'b0;
        m_addr     = m_pc;
      end
    end else begin
      if (f) begin
        m_pc = n;
        bubble();
        if (a) m_addr = n;
        else   m_dropping = 1'b1;
      end else if (a) begin
        if (s) begin
          m_buf = rd; m_buffered = 1'b1; m_req = 1'b0;
        end else begin
          m_id_pc = m_pc; m_id_ins = rd; m_id_valid = 1'b1;
          m_pc = n; m_addr = n;
        end
      end else if (!s) begin
        bubble();
      end
    end
  endtask

  task automatic check_all();
    check("pc",        32'(pc),        32'(m_pc));
    check("imem_req",  32'(imem_req),  32'(m_req));
    check("imem_addr", 32'(imem_addr), 32'(m_addr));
    check("id_pc",     32'(id_pc),     32'(m_id_pc));
    check("id_ins",    id_ins,         m_id_ins);
    check("id_valid",  32'(id_valid),  32'(m_id_valid));
  endtask

  // Apply one cycle of inputs, advance the model on the edge, compare just after it.
  task automatic cycle(input logic a, input logic s, input logic f, input logic [29:0] n);
    logic [31:0] rd;
    rd         = mem_word(m_addr);
    imem_ack   = a;
    stall      = s;
    if_flush   = f;
    npc        = n;
    imem_rdata = rd;
    @(posedge clk);
    model_edge(a, s, f, n, rd);
    #1;
    check_all();
  endtask

  initial begin
    int wait_cnt;
    logic a, s, f;
    logic [29:0] n;

    rst = 1'b0; stall = 1'b0; if_flush = 1'b0; imem_ack = 1'b0;
    npc = '0; imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_id_ins", id_ins, NOP);
    rst = 1'b1;

    // Idle cycle, then single-cycle acks with npc = pc + 1.
    cycle(1'b0, 1'b0, 1'b0, m_pc + 30'd1);
    check("first_req_addr", 32'(imem_addr), 32'h0000_0C00);
    cycle(1'b1, 1'b0, 1'b0, m_pc + 30'd1);
    cycle(1'b1, 1'b0, 1'b0, m_pc + 30'd1);
    check("second_addr", 32'(imem_addr), 32'h0000_0C02);
    check("stream_valid", 32'(id_valid), 32'd1);

    // Three-cycle latency: two bubbles per instruction.
    repeat (2) begin
      cycle(1'b0, 1'b0, 1'b0, m_pc + 30'd1);
      cycle(1'b0, 1'b0, 1'b0, m_pc + 30'd1);
      cycle(1'b1, 1'b0, 1'b0, m_pc + 30'd1);
    end

    // Ack under stall buffers the word; released two cycles later.
    cycle(1'b1, 1'b1, 1'b0, m_pc + 30'd1);
    check("hold_req_low", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, m_pc + 30'd1);
    cycle(1'b0, 1'b0, 1'b0, m_pc + 30'd1);
    check("hold_release_ins", id_ins, mem_word(30'h0000_0C04));

    // Flush with a request to 0xC05 outstanding.
    cycle(1'b0, 1'b0, 1'b1, 30'h0000_0D00);
    check("drop_old_addr", 32'(imem_addr), 32'h0000_0C05);
    check("drop_pc", 32'(pc), 32'h0000_0D00);
    cycle(1'b0, 1'b1, 1'b0, m_pc + 30'd1);
    cycle(1'b1, 1'b0, 1'b0, m_pc + 30'd1);
    check("drop_discard", 32'(id_valid), 32'd0);
    check("drop_redirect", 32'(imem_addr), 32'h0000_0D00);
    cycle(1'b1, 1'b0, 1'b0, m_pc + 30'd1);
    check("after_drop_id_pc", 32'(id_pc), 32'h0000_0D00);

    // Flush and stall together while holding a buffered word.
    cycle(1'b1, 1'b1, 1'b0, m_pc + 30'd1);
    cycle(1'b0, 1'b1, 1'b1, 30'h0000_0E00);
    check("hold_flush_valid", 32'(id_valid), 32'd0);
    check("hold_flush_req", 32'(imem_req), 32'd1);
    check("hold_flush_addr", 32'(imem_addr), 32'h0000_0E00);

    // Random traffic with a memory of 1..4 cycle latency.
    wait_cnt = $urandom_range(0, 3);
    for (int i = 0; i < 3000; i++) begin
      a = 1'b0;
      if (m_req) begin
        if (wait_cnt == 0) begin
          a = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 9) == 0);
      n = f ? 30'($urandom) : m_pc + 30'd1;
      cycle(a, s, f, n);
    end

    // Asynchronous reset in the middle of an outstanding fetch.
    cycle(1'b0, 1'b0, 1'b1, 30'h0000_1234);
    cycle(1'b0, 1'b0, 1'b0, m_pc + 30'd1);
    #2 rst = 1'b0;
    #1;
    check("async_pc",       32'(pc),        32'h0000_0C00);
    check("async_req",      32'(imem_req),  32'd0);
    check("async_addr",     32'(imem_addr), 32'h0000_0C00);
    check("async_id_pc",    32'(id_pc),     32'd0);
    check("async_id_ins",   id_ins,         NOP);
    check("async_id_valid", 32'(id_valid),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
